// File: rtl/avr_tx_arbiter.sv
// avr_tx_arbiter
// Shares the single AVR serial transmit channel among NUM_SRC message
// sources. A source is granted the channel for a whole message (or until
// MAX_LEN bytes have gone out), and each byte is handed to the AVR interface
// as a registered tx_data/new_tx_data strobe once tx_busy is low.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   src_req      per-source message pending (held until last byte acked)
//   src_data     per-source current byte, source i at [8*i+:8]
//   src_last     per-source "current byte is the final one"
//   src_gnt      one-hot channel owner, zero when idle
//   src_ack      one-cycle pulse: owner's current byte was taken
//   tx_busy      AVR transmitter busy, sampled only in SEND
//   tx_data      registered byte to the AVR
//   new_tx_data  registered one-cycle strobe qualifying tx_data
//   active_src   index of the current or most recent owner
//   overrun      one-cycle pulse: message hit MAX_LEN without src_last
//   state_dbg    current FSM state (IDLE=0, SEND=1, GAP=2)
//
// Handshake: in SEND with src_req[owner] high and tx_busy low, the byte on
// src_data[owner] is captured; during the following (GAP) cycle new_tx_data,
// tx_data and src_ack[owner] are high together, and the source must present
// its next byte before the cycle after that.
module avr_tx_arbiter #(
    parameter int NUM_SRC  = 3,
    parameter int MAX_LEN  = 64,
    parameter int SRC_BITS = $clog2(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    src_req,
    input  logic [8*NUM_SRC-1:0]  src_data,
    input  logic [NUM_SRC-1:0]    src_last,
    output logic [NUM_SRC-1:0]    src_gnt,
    output logic [NUM_SRC-1:0]    src_ack,
    input  logic                  tx_busy,
    output logic [7:0]            tx_data,
    output logic                  new_tx_data,
    output logic [SRC_BITS-1:0]   active_src,
    output logic                  overrun,
    output logic [1:0]            state_dbg
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     count, count_d, count_inc;
    logic                 last_q, last_d;
    logic [SRC_BITS-1:0]  last_owner, last_owner_d;
    logic [NUM_SRC-1:0]   gnt_d, ack_d;
    logic [7:0]           tx_data_d, sel_data;
    logic                 new_d, overrun_d;
    logic [SRC_BITS-1:0]  active_d;
    logic [SRC_BITS-1:0]  pick, cand;
    logic                 pick_valid;

    assign state_dbg = state;
    assign count_inc = count + CNT_W'(1);
    assign sel_data  = src_data[{active_src, 3'b000} +: 8];

    // Round-robin search starting just after the previous owner, so the
    // previous owner is considered last.
    always_comb begin
        pick       = '0;
        cand       = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SRC_BITS'((int'(last_owner) + k) % NUM_SRC);
            if (!pick_valid && src_req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        state_d      = state;
        count_d      = count;
        last_d       = last_q;
        last_owner_d = last_owner;
        gnt_d        = src_gnt;
        ack_d        = '0;
        tx_data_d    = tx_data;
        new_d        = 1'b0;
        overrun_d    = 1'b0;
        active_d     = active_src;

        case (state)
            IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    gnt_d[pick] = 1'b1;
                    active_d    = pick;
                    count_d     = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (!src_req[active_src]) begin
                    // Source abandoned its message: release without a byte.
                    gnt_d        = '0;
                    last_owner_d = active_src;
                    state_d      = IDLE;
                end else if (!tx_busy) begin
                    tx_data_d           = sel_data;
                    new_d               = 1'b1;
                    ack_d[active_src]   = 1'b1;
                    last_d              = src_last[active_src];
                    count_d             = count_inc;
                    // Registered here so the pulse lands in the GAP cycle of
                    // the byte that filled the message.
                    overrun_d = (count_inc == CNT_W'(MAX_LEN)) && !src_last[active_src];
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (last_q || count == CNT_W'(MAX_LEN)) begin
                    gnt_d        = '0;
                    last_owner_d = active_src;
                    state_d      = IDLE;
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            last_q      <= 1'b0;
            last_owner  <= SRC_BITS'(NUM_SRC - 1);
            src_gnt     <= '0;
            src_ack     <= '0;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
            overrun     <= 1'b0;
            active_src  <= '0;
        end else begin
            state       <= state_d;
            count       <= count_d;
            last_q      <= last_d;
            last_owner  <= last_owner_d;
            src_gnt     <= gnt_d;
            src_ack     <= ack_d;
            tx_data     <= tx_data_d;
            new_tx_data <= new_d;
            overrun     <= overrun_d;
            active_src  <= active_d;
        end
    end

endmodule

// File: doc/avr_tx_arbiter.md
# avr_tx_arbiter

Round-robin arbiter that shares the single AVR serial transmit channel among up to NUM_SRC message sources, such as the debug terminal printer and the command echo or telemetry formatters. It grants the channel to one source for a whole message, streams that source's bytes to the AVR interface using a per-byte ack handshake, and paces each byte against `tx_busy`. It sits between the message formatters and the AVR interface in the avionics top level.

## Interface
- NUM_SRC, 3, number of requesting sources (2..8)
- MAX_LEN, 64, maximum bytes per grant; a longer message is forcibly terminated
- SRC_BITS, $clog2(NUM_SRC), width of the source index
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- src_req  in  NUM_SRC  source i has a message pending; held high until its last byte is acked
- src_data  in  8*NUM_SRC  current byte of source i at [8*i+:8]
- src_last  in  NUM_SRC  current byte of source i is the final byte of its message
- src_gnt  out  NUM_SRC  one-hot owner of the channel; all zero when idle
- src_ack  out  NUM_SRC  one-cycle pulse: the current byte of source i was taken, so present the next one
- tx_busy  in  1  AVR transmitter busy
- tx_data  out  8  byte to the AVR, registered
- new_tx_data  out  1  one-cycle strobe, registered; qualifies tx_data
- active_src  out  SRC_BITS  index of the current or most recent owner
- overrun  out  1  one-cycle pulse: a message hit MAX_LEN without src_last

## Operation
- The FSM has three states: IDLE, SEND and GAP.
- **IDLE:** src_gnt = 0.
  - If any src_req is high, pick the first requester searching from (last_owner+1) mod NUM_SRC upward with wrap.
  - Register src_gnt (one-hot) and active_src, clear the byte counter, and go to SEND.
- **SEND:** owner o.
  - If src_req[o] is low, the source has abandoned its message. Go to IDLE, send no byte, and update last_owner to o.
  - Otherwise, if tx_busy is high, stay in SEND.
  - Otherwise, register tx_data <= src_data[o], new_tx_data <= 1 and src_ack[o] <= 1. Latch last = src_last[o], increment the count, and go to GAP.
- **GAP:** one guard cycle so that tx_busy can assert after the strobe.
  - If the latched last is set, or count == MAX_LEN, go to IDLE, drop src_gnt, and set last_owner = o.
  - If the count reached MAX_LEN while last was clear, pulse overrun.
  - Otherwise return to SEND.
- Requests that arrive while a message is in progress are never serviced mid-message. They are evaluated only in IDLE.
- A source that is still requesting after an overrun is treated as a new message and re-arbitrates normally, at its round-robin turn.
- Out-of-range src_data slots (index ≥ NUM_SRC) do not exist. The arbiter only selects an index in [0, NUM_SRC-1].
- The counter is $clog2(MAX_LEN+1) bits wide and never wraps.

## Timing
- **Reset values:** src_gnt=0, src_ack=0, tx_data=0, new_tx_data=0, active_src=0, overrun=0, state=IDLE, last_owner=NUM_SRC-1, so source 0 has first priority.
- **Reset mid-message:** all outputs clear immediately (asynchronously). The partial message is dropped without an ack.
- **Grant latency:** src_req high at cycle n (in IDLE) gives src_gnt at cycle n+1.
- **Byte handshake:** with tx_busy low at a SEND cycle k, new_tx_data, tx_data and src_ack are high during k+1 (the GAP cycle). The source must present its next byte by cycle k+2, which it achieves by registering on src_ack.
- **Throughput:** at most one byte per 2 cycles. tx_busy is sampled only in SEND.
- **First byte:** the earliest first byte strobe is at n+2.
- **Release:** src_gnt drops at the cycle after the GAP of the last byte. The next grant follows 1 cycle later, which is the mandatory IDLE cycle.
- **Arbitration input:** src_req of the previous owner in the IDLE cycle after release is considered at lowest priority only.

## Test plan
- **Single source:** source 1 sends the 3-byte message "AB\r" with tx_busy=0. Expect new_tx_data strobes 2 cycles apart carrying 0x41, 0x42, 0x0D, three src_ack[1] pulses, src_gnt=3'b010 for the whole message, then 0, and active_src=1.
- **Round-robin:** all three sources request 1-byte messages continuously from reset. Expect the grant order 0,1,2,0,1,2 with no interleaved bytes.
- **Backpressure:** tx_busy is held high for 10 cycles while source 0 is granted. Expect no strobe and no ack during that time, then the strobe on the cycle after tx_busy falls.
- **Overrun:** with MAX_LEN=4, source 2 sends 6 bytes and never asserts src_last. Expect 4 strobes, an overrun pulse in the GAP of byte 4, and the grant released. Source 2 regains the channel only after the other requesters are served.
- **Abandon and reset:**
  - Source 0 drops src_req after byte 1 of 5. Expect no further strobes and a return to IDLE.
  - Asserting rst during byte 2 of another message clears all outputs the same cycle, and source 0 has priority after reset.
